// File: rtl/rs_station.sv
// rs_station: Tomasulo reservation station.
// Holds up to DEPTH decoded ops with producer-tagged source operands.
// Operands are captured from the common data bus (CDB), and the oldest
// entry with both operands present is offered to a single functional unit.
//
// Handshakes (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. The dispatch side's disp_ready is computed
// only from registered occupancy. The issue side's iss_valid/iss_* come
// only from registered entry state, so they hold while iss_ready is low.
// The selection changes only when an older entry wakes up or a flush
// empties the station.
module rs_station #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 5,
  parameter int XLEN  = 32,
  parameter int OPW   = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OPW-1:0]           disp_op,
  input  logic [TAGW-1:0]          disp_tag,
  input  logic [TAGW-1:0]          disp_qj,
  input  logic [TAGW-1:0]          disp_qk,
  input  logic [XLEN-1:0]          disp_vj,
  input  logic [XLEN-1:0]          disp_vk,
  input  logic                     cdb_valid,
  input  logic [TAGW-1:0]          cdb_tag,
  input  logic [XLEN-1:0]          cdb_data,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OPW-1:0]           iss_op,
  output logic [TAGW-1:0]          iss_tag,
  output logic [XLEN-1:0]          iss_vj,
  output logic [XLEN-1:0]          iss_vk,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry storage
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OPW-1:0]   op_q  [DEPTH];
  logic [OPW-1:0]   op_d  [DEPTH];
  logic [TAGW-1:0]  tag_q [DEPTH];
  logic [TAGW-1:0]  tag_d [DEPTH];
  logic [TAGW-1:0]  qj_q  [DEPTH];
  logic [TAGW-1:0]  qj_d  [DEPTH];
  logic [TAGW-1:0]  qk_q  [DEPTH];
  logic [TAGW-1:0]  qk_d  [DEPTH];
  logic [XLEN-1:0]  vj_q  [DEPTH];
  logic [XLEN-1:0]  vj_d  [DEPTH];
  logic [XLEN-1:0]  vk_q  [DEPTH];
  logic [XLEN-1:0]  vk_d  [DEPTH];

  // Age matrix: older_q[i][j] = 1 means entry i was dispatched before
  // entry j. A newly written slot clears its row and sets its column,
  // making it younger than everything present. This keeps relative
  // order intact no matter which slots issue or get reused.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  logic [CW-1:0]    count_q, count_d;

  // Derived control
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] blocked;
  logic [DEPTH-1:0] grant;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    free_idx;
  logic             disp_fire;
  logic             iss_fire;
  logic             byp_j;
  logic             byp_k;

  // Entry readiness: valid with both producer tags cleared
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
  end

  // Oldest-ready select: an entry wins unless some older entry is also ready
  always_comb begin
    blocked = '0;
    grant   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && ready_vec[j] && older_q[j][i]) begin
          blocked[i] = 1'b1;
        end
      end
      grant[i] = ready_vec[i] && !blocked[i];
    end
  end

  // Encode the one-hot grant into the issue mux index
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_idx = IW'(i);
      end
    end
  end

  // Lowest-index free slot for dispatch
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IW'(i);
      end
    end
  end

  // Port-facing outputs, all derived from registered state
  always_comb begin
    disp_ready = (count_q < CW'(DEPTH));
    iss_valid  = |ready_vec;
    iss_op     = op_q[sel_idx];
    iss_tag    = tag_q[sel_idx];
    iss_vj     = vj_q[sel_idx];
    iss_vk     = vk_q[sel_idx];
    count      = count_q;
  end

  // Transfer qualifiers; a flush discards both transfers
  always_comb begin
    disp_fire = disp_valid && disp_ready && !flush;
    iss_fire  = iss_valid && iss_ready && !flush;
    byp_j     = cdb_valid && (disp_qj != '0) && (disp_qj == cdb_tag);
    byp_k     = cdb_valid && (disp_qk != '0) && (disp_qk == cdb_tag);
  end

  // Next-state: wakeup, issue retire, dispatch write, occupancy, flush
  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]    = op_q[i];
      tag_d[i]   = tag_q[i];
      qj_d[i]    = qj_q[i];
      qk_d[i]    = qk_q[i];
      vj_d[i]    = vj_q[i];
      vk_d[i]    = vk_q[i];
      older_d[i] = older_q[i];
    end

    // CDB wakeup of waiting operands; tag 0 never matches a producer
    if (cdb_valid && (cdb_tag != '0)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (qj_q[i] == cdb_tag)) begin
          qj_d[i] = '0;
          vj_d[i] = cdb_data;
        end
        if (valid_q[i] && (qk_q[i] == cdb_tag)) begin
          qk_d[i] = '0;
          vk_d[i] = cdb_data;
        end
      end
    end

    if (iss_fire) begin
      valid_d[sel_idx] = 1'b0;
    end

    // The free slot is invalid, so it can never be the issued entry
    if (disp_fire) begin
      valid_d[free_idx] = 1'b1;
      op_d[free_idx]    = disp_op;
      tag_d[free_idx]   = disp_tag;
      qj_d[free_idx]    = byp_j ? '0 : disp_qj;
      vj_d[free_idx]    = byp_j ? cdb_data : disp_vj;
      qk_d[free_idx]    = byp_k ? '0 : disp_qk;
      vk_d[free_idx]    = byp_k ? cdb_data : disp_vk;
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != int'(free_idx)) begin
          older_d[j][free_idx] = 1'b1;
        end
      end
    end

    case ({disp_fire, iss_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        tag_q[i]   <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= op_d[i];
        tag_q[i]   <= tag_d[i];
        qj_q[i]    <= qj_d[i];
        qk_q[i]    <= qk_d[i];
        vj_q[i]    <= vj_d[i];
        vk_q[i]    <= vk_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: directed-vector bench for rs_station (DEPTH=4).
module tb_rs_station;

  localparam int DEPTH = 4;
  localparam int TAGW  = 5;
  localparam int XLEN  = 32;
  localparam int OPW   = 17;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [OPW-1:0]    disp_op;
  logic [TAGW-1:0]   disp_tag;
  logic [TAGW-1:0]   disp_qj;
  logic [TAGW-1:0]   disp_qk;
  logic [XLEN-1:0]   disp_vj;
  logic [XLEN-1:0]   disp_vk;
  logic              cdb_valid;
  logic [TAGW-1:0]   cdb_tag;
  logic [XLEN-1:0]   cdb_data;
  logic              iss_valid;
  logic              iss_ready;
  logic [OPW-1:0]    iss_op;
  logic [TAGW-1:0]   iss_tag;
  logic [XLEN-1:0]   iss_vj;
  logic [XLEN-1:0]   iss_vk;
  logic [$clog2(DEPTH):0] count;

  int n_vec;
  int n_err;
  logic [TAGW-1:0] exp_q[$];

  rs_station #(.DEPTH(DEPTH), .TAGW(TAGW), .XLEN(XLEN), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_tag(disp_tag), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_vj(disp_vj), .disp_vk(disp_vk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_tag(iss_tag), .iss_vj(iss_vj), .iss_vk(iss_vk), .count(count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not finish");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush      = 1'b0;
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    cdb_tag    = '0;
    cdb_data   = '0;
  endtask

  task automatic drive_disp(input logic [TAGW-1:0] tag, input logic [TAGW-1:0] qj,
                            input logic [TAGW-1:0] qk, input logic [XLEN-1:0] vj,
                            input logic [XLEN-1:0] vk);
    disp_valid = 1'b1;
    disp_op    = {12'h5A5, tag};
    disp_tag   = tag;
    disp_qj    = qj;
    disp_qk    = qk;
    disp_vj    = vj;
    disp_vk    = vk;
  endtask

  task automatic drive_cdb(input logic [TAGW-1:0] tag, input logic [XLEN-1:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    iss_ready = 1'b0;
    disp_op = '0; disp_tag = '0; disp_qj = '0; disp_qk = '0;
    disp_vj = '0; disp_vk = '0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    check_val("rst_count", count, 0);
    check_val("rst_disp_ready", disp_ready, 1);
    check_val("rst_iss_valid", iss_valid, 0);

    // Single ready op: issue one cycle after dispatch
    drive_disp(5'd3, 5'd0, 5'd0, 32'd5, 32'd7);
    #1;
    check_val("no_same_cycle_issue", iss_valid, 0);
    step();
    idle();
    check_val("a_iss_valid", iss_valid, 1);
    check_val("a_iss_tag", iss_tag, 3);
    check_val("a_iss_op", iss_op, {12'h5A5, 5'd3});
    check_val("a_iss_vj", iss_vj, 5);
    check_val("a_iss_vk", iss_vk, 7);
    check_val("a_count", count, 1);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    check_val("a_drain_count", count, 0);
    check_val("a_drain_valid", iss_valid, 0);

    // Simultaneous dispatch and issue leave count unchanged
    drive_disp(5'd4, 5'd0, 5'd0, 32'd1, 32'd2);
    step();
    drive_disp(5'd5, 5'd0, 5'd0, 32'd3, 32'd4);
    iss_ready = 1'b1;
    step();
    idle();
    check_val("both_count", count, 1);
    check_val("both_next_tag", iss_tag, 5);
    step();
    iss_ready = 1'b0;
    check_val("both_drain_count", count, 0);

    // Older waiting op overtakes younger ready op once woken
    drive_disp(5'd1, 5'd4, 5'd0, 32'd0, 32'd2);
    step();
    drive_disp(5'd2, 5'd0, 5'd0, 32'h20, 32'h21);
    step();
    idle();
    check_val("b_presented", iss_tag, 2);
    step();
    check_val("b_held_valid", iss_valid, 1);
    check_val("b_held_tag", iss_tag, 2);
    drive_cdb(5'd4, 32'h10);
    step();
    idle();
    check_val("a_woken_tag", iss_tag, 1);
    check_val("a_woken_vj", iss_vj, 32'h10);
    check_val("a_woken_vk", iss_vk, 2);
    iss_ready = 1'b1;
    step();
    check_val("b_after_a", iss_tag, 2);
    check_val("b_after_a_count", count, 1);
    step();
    iss_ready = 1'b0;
    check_val("ab_drain_count", count, 0);

    // Fill to DEPTH, drop an extra dispatch, then drain in order
    for (int k = 0; k < DEPTH; k++) begin
      drive_disp(TAGW'(5 + k), 5'd9, 5'd0, 32'd0, XLEN'(k));
      step();
    end
    idle();
    check_val("full_count", count, 4);
    check_val("full_disp_ready", disp_ready, 0);
    check_val("full_iss_valid", iss_valid, 0);
    drive_disp(5'd10, 5'd0, 5'd0, 32'd1, 32'd1);
    step();
    idle();
    check_val("dropped_count", count, 4);
    check_val("dropped_iss_valid", iss_valid, 0);
    drive_cdb(5'd9, 32'h99);
    step();
    idle();
    iss_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check_val("fill_order_tag", iss_tag, 5 + k);
      check_val("fill_order_vj", iss_vj, 32'h99);
      check_val("fill_order_vk", iss_vk, k);
      step();
    end
    iss_ready = 1'b0;
    check_val("fill_drain_count", count, 0);
    check_val("fill_drain_valid", iss_valid, 0);

    // Age order survives slot reuse: a younger op lands in a lower slot
    drive_disp(5'd11, 5'd15, 5'd0, 32'd0, 32'd0);
    step();
    drive_disp(5'd12, 5'd0, 5'd0, 32'd0, 32'd0);
    step();
    drive_disp(5'd13, 5'd15, 5'd0, 32'd0, 32'd0);
    step();
    idle();
    check_val("age_first_ready", iss_tag, 12);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    check_val("age_count2", count, 2);
    check_val("age_none_ready", iss_valid, 0);
    drive_disp(5'd14, 5'd15, 5'd0, 32'd0, 32'd0);
    step();
    idle();
    check_val("age_count3", count, 3);
    drive_cdb(5'd15, 32'h55);
    step();
    idle();
    exp_q.push_back(5'd11);
    exp_q.push_back(5'd13);
    exp_q.push_back(5'd14);
    iss_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check_val("age_order", iss_tag, exp_q.pop_front());
      step();
    end
    iss_ready = 1'b0;
    check_val("age_drain_count", count, 0);

    // Dispatch-time CDB bypass, single and double source
    drive_disp(5'd20, 5'd0, 5'd6, 32'd1, 32'd0);
    drive_cdb(5'd6, 32'hAB);
    step();
    idle();
    check_val("byp_k_valid", iss_valid, 1);
    check_val("byp_k_vk", iss_vk, 32'hAB);
    check_val("byp_k_vj", iss_vj, 1);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    drive_disp(5'd21, 5'd7, 5'd7, 32'd0, 32'd0);
    drive_cdb(5'd7, 32'h77);
    step();
    idle();
    check_val("byp_jk_valid", iss_valid, 1);
    check_val("byp_jk_vj", iss_vj, 32'h77);
    check_val("byp_jk_vk", iss_vk, 32'h77);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    check_val("byp_drain_count", count, 0);

    // Flush discards same-cycle dispatch, issue and CDB capture
    drive_disp(5'd22, 5'd0, 5'd0, 32'd9, 32'd9);
    step();
    drive_disp(5'd23, 5'd30, 5'd0, 32'd0, 32'd0);
    step();
    drive_disp(5'd24, 5'd30, 5'd0, 32'd0, 32'd0);
    step();
    idle();
    check_val("pre_flush_count", count, 3);
    drive_disp(5'd25, 5'd0, 5'd0, 32'd1, 32'd1);
    drive_cdb(5'd30, 32'h3);
    flush = 1'b1;
    iss_ready = 1'b1;
    step();
    idle();
    iss_ready = 1'b0;
    check_val("flush_count", count, 0);
    check_val("flush_iss_valid", iss_valid, 0);
    check_val("flush_disp_ready", disp_ready, 1);
    drive_cdb(5'd30, 32'h3);
    step();
    idle();
    check_val("post_flush_cdb", iss_valid, 0);

    // Reset mid-stream clears entries; stale tags wake nothing
    for (int k = 0; k < 3; k++) begin
      drive_disp(TAGW'(26 + k), 5'd29, 5'd0, 32'd0, 32'd0);
      step();
    end
    idle();
    check_val("pre_rst_count", count, 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_val("mid_rst_count", count, 0);
    check_val("mid_rst_iss_valid", iss_valid, 0);
    check_val("mid_rst_disp_ready", disp_ready, 1);
    drive_cdb(5'd29, 32'h1);
    step();
    idle();
    check_val("post_rst_cdb_valid", iss_valid, 0);
    check_val("post_rst_cdb_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
